// File: rtl/lane_seq_ctrl.sv
// lane_seq_ctrl: streams one genome from gene memory into a processing lane.
// Reads are issued straight from the FSM (1-cycle SRAM latency), returning
// data lands in a 2-entry skid buffer whose head drives the lane.
// Optional feature macro: LANE_SEQ_EVAL_PASS_EN (adds a second, EVAL pass).
//
// Handshake: a lane beat transfers on any rising edge where
// lane_valid && lane_ready; while lane_valid && !lane_ready the beat
// (lane_gene) holds stable, and lane_valid never drops without a transfer.
//
// The FSM state register state_q is the observation point for checkers.
module lane_seq_ctrl #(
    parameter int GENE_SZ = 64,
    parameter int ADDR_SZ = 10,
    parameter int CNT_SZ  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_SZ-1:0] base_addr,
    input  logic [CNT_SZ-1:0]  gene_cnt,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_SZ-1:0] mem_addr,
    input  logic [GENE_SZ-1:0] mem_rd_data,
    output logic [1:0]         lane_state,
    output logic [GENE_SZ-1:0] lane_gene,
    output logic               lane_valid,
    input  logic               lane_ready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
`ifdef LANE_SEQ_EVAL_PASS_EN
        ST_EVAL  = 3'd2,
`endif
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [1:0] PH_SCAN = 2'b00;
    localparam logic [1:0] PH_EVAL = 2'b01;
    localparam logic [1:0] PH_IDLE = 2'b11;

    // FSM and run context
    state_t              state_q, state_d;
    logic [CNT_SZ-1:0]   cnt_q, cnt_d;
    logic [ADDR_SZ-1:0]  rd_addr_q, rd_addr_d;
    logic [CNT_SZ-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_SZ-1:0]   acc_cnt_q, acc_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef LANE_SEQ_EVAL_PASS_EN
    logic [ADDR_SZ-1:0]  base_q, base_d;
`endif

    // Read pipeline and skid buffer (entry 0 is the head)
    logic                inflight_q, inflight_d;
    logic [GENE_SZ-1:0]  skid0_q, skid0_d;
    logic [GENE_SZ-1:0]  skid1_q, skid1_d;
    logic [1:0]          sk_cnt_q, sk_cnt_d;

    // Flow-control terms
    logic                in_pass;
    logic                reads_left;
    logic [1:0]          occ;
    logic                pop;
    logic                push;
    logic                issue;
    logic                last_acc;

    // Flow control: occupancy counts the read in flight plus buffered genes,
    // so a new read is only issued when its data is guaranteed a slot.
    always_comb begin
        in_pass    = (state_q == ST_SCAN)
`ifdef LANE_SEQ_EVAL_PASS_EN
                     || (state_q == ST_EVAL)
`endif
                     ;
        lane_valid = (sk_cnt_q != 2'd0);
        pop        = lane_valid && lane_ready;
        push       = inflight_q;
        occ        = sk_cnt_q + {1'b0, inflight_q};
        reads_left = in_pass && (rd_cnt_q != cnt_q);
        issue      = reads_left && !rst &&
                     ((occ < 2'd2) || ((occ == 2'd2) && pop));
        last_acc   = in_pass && pop && (acc_cnt_q == (cnt_q - CNT_SZ'(1)));
    end

    // Output decode: memory strobe/address and lane phase/gene
    always_comb begin
        mem_rd_en = issue;
        mem_addr  = issue ? rd_addr_q : '0;
        lane_gene = lane_valid ? skid0_q : '0;
        busy      = busy_q;
        done      = done_q;
        case (state_q)
            ST_SCAN: lane_state = PH_SCAN;
`ifdef LANE_SEQ_EVAL_PASS_EN
            ST_EVAL: lane_state = PH_EVAL;
`endif
            default: lane_state = PH_IDLE;
        endcase
    end

    // Skid buffer next state: FIFO order kept on simultaneous push and pop
    always_comb begin
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        sk_cnt_d   = sk_cnt_q;
        inflight_d = issue;
        case ({push, pop})
            2'b10: begin
                if (sk_cnt_q == 2'd0) begin
                    skid0_d = mem_rd_data;
                end else begin
                    skid1_d = mem_rd_data;
                end
                sk_cnt_d = sk_cnt_q + 2'd1;
            end
            2'b01: begin
                skid0_d  = skid1_q;
                sk_cnt_d = sk_cnt_q - 2'd1;
            end
            2'b11: begin
                if (sk_cnt_q == 2'd1) begin
                    skid0_d = mem_rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    // FSM next state, pass counters and run status
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        rd_cnt_d  = rd_cnt_q;
        acc_cnt_d = acc_cnt_q;
        busy_d    = (state_q != ST_IDLE) && (state_q != ST_FIN);
        done_d    = (state_q == ST_FIN);
`ifdef LANE_SEQ_EVAL_PASS_EN
        base_d    = base_q;
`endif

        if (issue) begin
            rd_addr_d = rd_addr_q + ADDR_SZ'(1);
            rd_cnt_d  = rd_cnt_q + CNT_SZ'(1);
        end
        if (in_pass && pop) begin
            acc_cnt_d = acc_cnt_q + CNT_SZ'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (gene_cnt != '0) begin
                        cnt_d     = gene_cnt;
                        rd_addr_d = base_addr;
                        rd_cnt_d  = '0;
                        acc_cnt_d = '0;
`ifdef LANE_SEQ_EVAL_PASS_EN
                        base_d    = base_addr;
`endif
                        state_d   = ST_SCAN;
                    end else begin
                        state_d   = ST_FIN;
                    end
                end
            end
            ST_SCAN: begin
                // Pass ends on the final accept; lane_state keeps the pass
                // code during that cycle so the last beat sees the right phase.
                if (last_acc) begin
`ifdef LANE_SEQ_EVAL_PASS_EN
                    rd_addr_d = base_q;
                    rd_cnt_d  = '0;
                    acc_cnt_d = '0;
                    state_d   = ST_EVAL;
`else
                    state_d   = ST_DRAIN;
`endif
                end
            end
`ifdef LANE_SEQ_EVAL_PASS_EN
            ST_EVAL: begin
                if (last_acc) begin
                    state_d = ST_DRAIN;
                end
            end
`endif
            ST_DRAIN: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any run and drops in-flight data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            acc_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            sk_cnt_q   <= 2'd0;
`ifdef LANE_SEQ_EVAL_PASS_EN
            base_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            sk_cnt_q   <= sk_cnt_d;
`ifdef LANE_SEQ_EVAL_PASS_EN
            base_q     <= base_d;
`endif
        end
    end

endmodule

// File: tb/tb_lane_seq_ctrl.sv
// Bench for lane_seq_ctrl: random gene memory, lane back-pressure patterns,
// expected beats/addresses derived from the run parameters and queued.
module tb_lane_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  gene_cnt;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [63:0] mem_rd_data;
  logic [1:0]  lane_state;
  logic [63:0] lane_gene;
  logic        lane_valid;
  logic        lane_ready;

  lane_seq_ctrl #(.GENE_SZ(64), .ADDR_SZ(10), .CNT_SZ(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .gene_cnt(gene_cnt), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .lane_state(lane_state),
    .lane_gene(lane_gene), .lane_valid(lane_valid), .lane_ready(lane_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- gene memory model (1-cycle read latency) ----------------
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    else           mem_rd_data <= {$urandom, $urandom};
  end

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];
  int total = 0;
  int bad   = 0;
  int issued = 0;
  int pops = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;
  int ready_mode = 0;
  int pat_i = 0;
  int passes;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_gene = '0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- lane back-pressure driver ----------------
  initial begin
    lane_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: lane_ready = 1'b1;
        1: begin
          lane_ready = (pat_i == 0) || (pat_i == 3);
          pat_i = (pat_i + 1) % 4;
        end
        default: lane_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (lane_valid && lane_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got %h expected none", {lane_state, lane_gene});
        end else begin
          chk("beat", {lane_state, lane_gene}, exp_q.pop_front());
        end
        pops++;
        last_pop_cyc = cyc;
      end
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: got addr %h expected none", mem_addr);
        end else begin
          chk("rd_addr", {56'd0, mem_addr}, {56'd0, exp_addr_q.pop_front()});
        end
        issued++;
      end
      if (!lane_valid) chk("idle_gene_zero", {2'b00, lane_gene}, 66'd0);
      if (prev_stall) chk("stall_hold", {1'b0, lane_valid, lane_gene}, {1'b0, 1'b1, prev_gene});
      chk("occupancy_le2", {65'd0, (issued - pops) <= 2}, 66'd1);
      prev_stall = lane_valid && !lane_ready;
      prev_gene  = lane_gene;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_check(input string nm);
    chk(nm, {52'd0, lane_state, lane_valid, lane_gene == 64'd0, busy, done, mem_rd_en, mem_addr},
            {52'd0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
  endtask

  task automatic run_seq(input int base, input int cnt, input int mode, input bit poke);
    int d_cyc;
    int s_cyc;
    int t;
    int exp_last;
    ready_mode = mode;
    pat_i = 0;
    issued = 0;
    pops = 0;
    done_cnt = 0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back({(p == 0) ? 2'b00 : 2'b01, mem[(base + i) & 1023]});
        exp_addr_q.push_back(10'((base + i) & 1023));
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 10'(base);
    gene_cnt = 10'(cnt);
    d_cyc = cyc;
    s_cyc = d_cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 10'($urandom);
    gene_cnt = 10'($urandom_range(1, 20));
    @(negedge clk); #1;
    chk("busy_after_start", {65'd0, busy}, 66'd1);
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      @(negedge clk); #1;
    end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected one (base=%0d cnt=%0d)", base, cnt);
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 66'(done_cnt), 66'd1);
    chk("busy_low_after", {65'd0, busy}, 66'd0);
    chk("beats_left", 66'(exp_q.size()), 66'd0);
    chk("reads_left", 66'(exp_addr_q.size()), 66'd0);
    chk("beat_count", 66'(pops), 66'(cnt * passes));
    if (cnt == 0) begin
      chk("done_latency_empty", 66'(done_cyc - d_cyc), 66'd2);
    end else begin
      chk("done_after_last_beat", 66'(done_cyc - last_pop_cyc), 66'd3);
      if (mode == 0) begin
        // first beat 2 cycles into each pass, then one beat per cycle
        t = s_cyc;
        exp_last = 0;
        for (int p = 0; p < passes; p++) begin
          exp_last = t + 1 + cnt;
          t = exp_last + 1;
        end
        chk("full_rate_timing", 66'(last_pop_cyc), 66'(exp_last));
      end
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
`ifdef LANE_SEQ_EVAL_PASS_EN
    passes = 2;
`else
    passes = 1;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom | 32'h1};
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    gene_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      idle_check("reset_idle");
    end

    run_seq(32'h010, 4, 0, 1'b0);
    run_seq(32'h010, 4, 1, 1'b1);
    run_seq(32'h020, 0, 0, 1'b0);
    run_seq(32'h3FE, 4, 0, 1'b0);
    run_seq(32'h3FC, 1, 0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      run_seq(int'($urandom_range(0, 1023)), int'($urandom_range(1, 24)), 2, r[0]);
    end
    run_seq(32'h2F0, 40, 0, 1'b0);

    // abort an 8-gene run after two beats
    ready_mode = 0;
    issued = 0;
    pops = 0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({2'b00, mem[(32'h080 + i) & 1023]});
      exp_addr_q.push_back(10'((32'h080 + i) & 1023));
    end
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 10'h080;
    gene_cnt = 10'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && pops < 2; k++) begin
      @(negedge clk); #1;
    end
    chk("abort_reached_beats", {65'd0, pops >= 2}, 66'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    idle_check("abort_reset_vals");
    exp_q.delete();
    exp_addr_q.delete();
    issued = 0;
    pops = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      idle_check("abort_quiet");
    end
    chk("abort_no_done", 66'(done_cnt), 66'd0);
    run_seq(32'h100, 3, 0, 1'b0);
    run_seq(32'h104, 3, 2, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
